// File: rtl/dip_switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// dip_switch_debouncer_if : raw switch levels in, conditioned vector out
// Rev 1.0
// ============================================================================
interface dip_switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] stable_out;
  logic             changed;
  logic             settling;

  modport master (output raw_in, input stable_out, input changed, input settling);
  modport slave  (input raw_in, output stable_out, output changed, output settling);
endinterface
`default_nettype wire

// File: rtl/dip_switch_debouncer.sv
`default_nettype none
// ============================================================================
// dip_switch_debouncer : 2-flop synchronizer plus whole-vector debounce
// Rev 1.0
// ============================================================================
module dip_switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  wire                    clk,
  input  wire                    rst,
  dip_switch_debouncer_if.slave  bus
);
  localparam int              CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_q, changed_d;

  always_comb begin
    sync1_d   = bus.raw_in;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    // Any difference on any bit restarts qualification of the whole vector.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d  = cand_q;
        changed_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign bus.stable_out = stable_q;
  assign bus.changed    = changed_q;
  assign bus.settling   = (cand_q != stable_q);
endmodule
`default_nettype wire

// File: tb/tb_dip_switch_debouncer.sv
`default_nettype none
// ============================================================================
// tb_dip_switch_debouncer : directed checks of default and minimum windows
// Rev 1.0
// ============================================================================
module tb_dip_switch_debouncer;
  localparam int S = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dip_switch_debouncer_if #(.WIDTH(8)) bus_a ();
  dip_switch_debouncer_if #(.WIDTH(8)) bus_b ();

  dip_switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(S)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dip_switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step_check(input string tag, input logic [7:0] exp_stable, input logic exp_changed,
                            input logic exp_settling, input logic chk_settle);
    @(posedge clk);
    #1;
    check_eq({tag, " stable"}, 32'(bus_a.stable_out), 32'(exp_stable));
    check_eq({tag, " changed"}, 32'(bus_a.changed), 32'(exp_changed));
    if (chk_settle)
      check_eq({tag, " settling"}, 32'(bus_a.settling), 32'(exp_settling));
  endtask

  // Input already applied ahead of edge 1; update lands on edge S+3.
  task automatic expect_clean(input string tag, input logic [7:0] old_v, input logic [7:0] new_v);
    for (int e = 1; e <= S + 6; e++)
      step_check(tag, (e >= S + 3) ? new_v : old_v, (e == S + 3), (e >= 3 && e < S + 3), 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " stable"}, 32'(bus_a.stable_out), 32'h0);
    check_eq({tag, " changed"}, 32'(bus_a.changed), 32'h0);
    check_eq({tag, " settling"}, 32'(bus_a.settling), 32'h0);
  endtask

  initial begin
    logic [7:0] exp_b;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus_a.raw_in  = 8'h00;
    bus_b.raw_in  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check_eq("reset b stable", 32'(bus_b.stable_out), 32'h0);
    check_eq("reset b changed", 32'(bus_b.changed), 32'h0);

    // Release with 0xA5 held: qualifies normally, one pulse.
    bus_a.raw_in = 8'hA5;
    #4 rst = 1'b0;
    expect_clean("release A5", 8'h00, 8'hA5);

    // Asynchronous assertion clears outputs before any edge.
    #3 rst = 1'b1;
    #1 check_zero("async reset");
    @(posedge clk);
    #5 rst = 1'b0;
    expect_clean("rerelease A5", 8'h00, 8'hA5);

    // Reset during settling: candidate discarded, no pulse afterwards.
    bus_a.raw_in = 8'h3C;
    for (int e = 1; e <= 8; e++)
      step_check("pre-reset settle", 8'hA5, 1'b0, (e >= 3), 1'b1);
    #3 rst = 1'b1;
    #1 check_zero("reset mid-settle");
    bus_a.raw_in = 8'h00;
    @(posedge clk);
    #5 rst = 1'b0;
    for (int e = 1; e <= 25; e++)
      step_check("post-reset quiet", 8'h00, 1'b0, 1'b0, 1'b1);

    bus_a.raw_in = 8'h01;
    expect_clean("clean 00->01", 8'h00, 8'h01);
    bus_a.raw_in = 8'h00;
    expect_clean("clean 01->00", 8'h01, 8'h00);

    // Short excursion returns to the held value: no update, no pulse.
    bus_a.raw_in = 8'h80;
    for (int e = 1; e <= 30; e++) begin
      step_check("glitch", 8'h00, 1'b0, (e >= 3 && e < 9), 1'b1);
      if (e == 6) bus_a.raw_in = 8'h00;
    end

    for (int k = 0; k < 8; k++) begin
      bus_a.raw_in = (k % 2 == 0) ? 8'h01 : 8'h00;
      for (int c = 0; c < 5; c++)
        step_check("bounce", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    bus_a.raw_in = 8'h01;
    expect_clean("bounce settle", 8'h00, 8'h01);

    // One-cycle 0x07 lands in sync2 just before qualification would finish.
    bus_a.raw_in = 8'h03;
    for (int e = 1; e <= 38; e++) begin
      step_check("late restart", (e >= 35) ? 8'h03 : 8'h01, (e == 35), (e >= 3 && e < 35), 1'b1);
      if (e == 15) bus_a.raw_in = 8'h07;
      else if (e == 16) bus_a.raw_in = 8'h03;
    end

    // Minimum window on the second instance: 5-edge latency per change.
    bus_b.raw_in = 8'h10;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      exp_b = (e >= 11) ? 8'h30 : (e >= 8) ? 8'h20 : (e >= 5) ? 8'h10 : 8'h00;
      check_eq("min window stable", 32'(bus_b.stable_out), 32'(exp_b));
      check_eq("min window changed", 32'(bus_b.changed), 32'(e == 5 || e == 8 || e == 11));
      check_eq("min window settling", 32'(bus_b.settling),
               32'(e == 3 || e == 4 || e == 6 || e == 7 || e == 9 || e == 10));
      if (e == 3) bus_b.raw_in = 8'h20;
      else if (e == 6) bus_b.raw_in = 8'h30;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
